button_conditioner: RTL
=======================

# button_conditioner

Parametrised multi-channel successor to the single toggle flip-flop of the chronometer lab. It samples N_CH raw push-buttons against a slow tick derived from clk_sl, debounces each one, and emits per-channel level, press/release pulses, a toggle state and a long-press hold pulse, all synchronous to clk_ms. It sits between the board buttons and the chronometer control FSM, which consumes start/stop as toggle and reset/lap as press and hold pulses.

## Interface
- N_CH, 3: number of independent button channels.
- DEB_TICKS, 3: consecutive clk_sl ticks of a stable, differing input required to change the debounced level; range 1..15.
- HOLD_TICKS, 8: ticks of continuous debounced press before hold_pulse fires; 0 disables hold.
- ACTIVE_LOW, 0: 1 means btn_in is inverted at input, so a pressed button reads 0.

- clk_ms  in  1  master clock; all state is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- clk_sl  in  1  slow clock, treated as data; each synchronised rising edge is one tick.
- btn_in  in  N_CH  raw asynchronous buttons.
- clr_toggle  in  N_CH  synchronous per-channel clear of toggle_state.
- level  out  N_CH  debounced pressed level.
- press_pulse  out  N_CH  one clk_ms pulse on the debounced 0→1 transition.
- release_pulse  out  N_CH  one clk_ms pulse on the debounced 1→0 transition.
- toggle_state  out  N_CH  flips on every press_pulse.
- hold_pulse  out  N_CH  one pulse per press once held for HOLD_TICKS.

## Operation
- Synchronisers: btn_in (after polarity correction) and clk_sl each pass through 2 flip-flops.
- Tick: tick = sync_sl & ~sl_old. It is registered and is high for exactly one clk_ms cycle per clk_sl rising edge. It is shared by all channels.
- Debounce, per channel, with counter deb_cnt of width clog2(DEB_TICKS+1). Evaluated only on tick cycles:
  - If the sample equals level, deb_cnt ← 0.
  - Otherwise, if deb_cnt == DEB_TICKS-1, level flips and deb_cnt ← 0.
  - Otherwise deb_cnt increments.
- Pulses: press_pulse and release_pulse are registered alongside level. They are asserted in the same cycle level first shows its new value and are deasserted on the next cycle.
- Toggle:
  - On press_pulse, toggle_state inverts.
  - clr_toggle forces toggle_state to 0.
  - clr_toggle wins over a simultaneous press, so the result is 0.
- Hold, with counter hold_cnt of width clog2(HOLD_TICKS+1), saturating:
  - Cleared while level == 0.
  - Increments on each tick while level == 1.
  - hold_pulse fires in the cycle hold_cnt reaches HOLD_TICKS, and at most once per press.
  - Release then re-press re-arms it.
  - The hold counter does not count on the tick cycle that raises level.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset values: level, press_pulse, release_pulse, toggle_state and hold_pulse are all 0. All counters are 0, as are the tick registers.
- Synchroniser flops reset to the idle value: 0 after polarity correction, i.e. raw 1 when ACTIVE_LOW.
- Reset mid-press: all outputs drop next cycle. A button still held must then be re-debounced for DEB_TICKS ticks. It then produces a fresh press_pulse and does not toggle twice.
- Latency from btn_in change to level: 2 cycles sync, plus the wait to the next tick, plus (DEB_TICKS-1) further ticks, plus 1 cycle.
- Glitch rejection: any input reversal before DEB_TICKS consecutive ticks resets deb_cnt, and no output changes.
- clk_sl must be held at least 2 clk_ms cycles high and 2 low. Faster clk_sl is out of spec.

## Structure
- Package button_pkg holds:
  - Default constants DEB_TICKS_DEF=3 and HOLD_TICKS_DEF=8.
  - A clog2 width function.
- Top level holds the clk_sl synchroniser and tick generator.
- Sub-module button_channel, generated N_CH times, holds the input sync, debounce counter, pulse/toggle logic and hold counter.

## Test plan
Bench configuration: N_CH=2, DEB_TICKS=3, HOLD_TICKS=5, ACTIVE_LOW=0, tick every 8 clk_ms.
- Reset: assert rst for 2 cycles with btn_in=2'b11 held → all outputs 0. level[1:0]=11 only after 3 ticks, with press_pulse=11 for exactly 1 cycle.
- Bounce: ch0 high for 2 ticks, low 1 tick, high 3 ticks → exactly one press_pulse, aligned to the 3rd tick of the final run. toggle_state[0]=1.
- Toggle/clear: press and release ch1 twice → toggle_state[1] goes 1 then 0. Then assert clr_toggle[1] in the same cycle as a third press_pulse → toggle_state[1]=0.
- Hold: hold ch0 for 10 ticks after level rises → exactly one hold_pulse, 5 ticks after the rise. Release gives release_pulse. Re-hold gives a second hold_pulse.
- Reset mid-hold: rst at tick 3 of a hold → outputs 0 next cycle. Re-press completes after 3 ticks with no hold_pulse until 5 ticks after that.
- ACTIVE_LOW=1 rerun: raw idle 1 yields no pulses after reset. Raw 0 for 3 ticks yields press_pulse.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and helpers for the button conditioner.
package button_pkg;

  localparam int unsigned DEB_TICKS_DEF  = 3;
  localparam int unsigned HOLD_TICKS_DEF = 8;

  // Bits needed to hold values 0..n-1; never less than 1 bit.
  function automatic int unsigned clog2w(input int unsigned n);
    int unsigned w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: input synchroniser, tick-based debounce, press/release
// pulses, toggle state and long-press hold pulse.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
  parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk_ms,
  input  logic rst,
  input  logic tick,
  input  logic btn_in,
  input  logic clr_toggle,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle_state,
  output logic hold_pulse
);

  localparam int unsigned DW = clog2w(DEB_TICKS + 1);
  localparam int unsigned HW = clog2w(HOLD_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

  logic          b_s1;
  logic          b_s2;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  // Polarity-correct and synchronise the raw button; idle value is 0.
  always_ff @(posedge clk_ms) begin
    if (rst) begin
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      b_s1 <= btn_in ^ ACTIVE_LOW;
      b_s2 <= b_s1;
    end
  end

  // Debounce on ticks; edge pulses are registered together with level.
  always_ff @(posedge clk_ms) begin
    if (rst) begin
      level         <= 1'b0;
      deb_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (tick) begin
        if (b_s2 == level) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          level         <= ~level;
          deb_cnt       <= '0;
          press_pulse   <= ~level;
          release_pulse <= level;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  // Toggle follows the visible press pulse; a clear in that cycle wins.
  always_ff @(posedge clk_ms) begin
    if (rst) begin
      toggle_state <= 1'b0;
    end else if (clr_toggle) begin
      toggle_state <= 1'b0;
    end else if (press_pulse) begin
      toggle_state <= ~toggle_state;
    end
  end

  // Saturating hold counter; pulse fires once when it reaches HOLD_TICKS.
  always_ff @(posedge clk_ms) begin
    if (rst) begin
      hold_cnt   <= '0;
      hold_pulse <= 1'b0;
    end else begin
      hold_pulse <= 1'b0;
      if (!level) begin
        hold_cnt <= '0;
      end else if (tick && (HOLD_TICKS != 0) && (hold_cnt != HOLD_MAX)) begin
        hold_cnt   <= hold_cnt + 1'b1;
        hold_pulse <= (hold_cnt == HOLD_LAST);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: shared clk_sl tick generator feeding
// N_CH independent debounce channels.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
  parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic            clk_ms,
  input  logic            rst,
  input  logic            clk_sl,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] clr_toggle,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] toggle_state,
  output logic [N_CH-1:0] hold_pulse
);

  logic sl_s1;
  logic sl_s2;
  logic sl_old;
  logic tick;

  // Synchronise clk_sl and register a one-cycle tick on each rising edge.
  always_ff @(posedge clk_ms) begin
    if (rst) begin
      sl_s1  <= 1'b0;
      sl_s2  <= 1'b0;
      sl_old <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sl_s1  <= clk_sl;
      sl_s2  <= sl_s1;
      sl_old <= sl_s2;
      tick   <= sl_s2 & ~sl_old;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DEB_TICKS  (DEB_TICKS),
      .HOLD_TICKS (HOLD_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk_ms        (clk_ms),
      .rst           (rst),
      .tick          (tick),
      .btn_in        (btn_in[i]),
      .clr_toggle    (clr_toggle[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .toggle_state  (toggle_state[i]),
      .hold_pulse    (hold_pulse[i])
    );
  end

endmodule
